fwd_scoreboard: RTL and testbench
=================================

// Module: fwd_scoreboard
// PURPOSE
//  Parametrised forwarding/hazard unit for the rv32 pipeline; generalises the 2-port EX/M bypasser.
//  Tracks a tag pipeline of in-flight register writes over NSTAGE stages past ID (stage 0 = EX).
//  Each entry records dest reg and the stage at which its result becomes valid.
//  Per ID read port: forwards from the youngest matching ready entry, or raises stall if that entry is not ready.
//  Sits beside the ID/EX register; stage datapaths supply their result buses.
// PARAMETERS
//  XLEN    32  datapath width
//  NSTAGE  3   tracked stages after ID (0=EX,1=M,2=WB); >=2
//  NRD     2   ID read ports
//  RDYW    2   width of ready-stage field, >= clog2(NSTAGE)
//  CNTW    16  stall performance counter width
// PORTS
//  clk        in   1            clock
//  rst        in   1            synchronous reset, active-high
//  id_valid   in   1            valid instruction in ID
//  id_rnum    in   NRD*5        source reg numbers, port p at [5p+:5]
//  id_wr      in   1            ID instruction writes a register
//  id_wnum    in   5            ID dest reg
//  id_rdy_stg in   RDYW         first stage whose stg_data holds the result (0=ALU, 1=load)
//  pipe_hold  in   1            global freeze (memory wait)
//  flush      in   1            kill ID and stage-0 instructions (branch resolved in EX)
//  stg_data   in   NSTAGE*XLEN  result bus per stage, stage k at [k*XLEN+:XLEN]
//  fwd_hit    out  NRD          port p takes fwd_data instead of regfile
//  fwd_data   out  NRD*XLEN     forwarded operand per port
//  stall      out  1            hold PC/IF/ID, insert bubble into stage 0
//  stall_cnt  out  CNTW         saturating count of stall cycles
// BEHAVIOUR
//  - Entry k = {v, wnum, rdy_stg}. v=1 only when the writer has id_wr=1 and wnum!=0.
//  - Entry k is ready iff k >= rdy_stg.
//  - Match (port p, stage k): v_k & wnum_k==id_rnum[p] & id_rnum[p]!=0. The lowest k (youngest) wins.
//  - Youngest match ready -> fwd_hit[p]=1, fwd_data[p]=stg_data[k].
//  - Youngest match not ready -> fwd_hit[p]=0, stall request.
//  - No match -> fwd_hit[p]=0, fwd_data[p]=0.
//  - An older ready match never overrides a younger unready one.
//  - stall = id_valid & !flush & any port requests a stall. Combinational, zero latency.
//  - Sequential update at posedge clk, priority rst > pipe_hold > normal:
//    * rst: all v=0, stall_cnt=0. Outputs settle to fwd_hit=0, fwd_data=0, stall=0 in the same cycle.
//    * pipe_hold: tag pipeline and stall_cnt frozen. Outputs still evaluated on current state.
//    * normal: entry k <= entry k-1 for k>=1. The last stage retires.
//    * entry 0 <= bubble if flush | stall | !id_valid, else the ID tag.
//    * flush: additionally entry 1 <= bubble (stage-0 op killed). flush overrides stall.
//  - stall_cnt increments when stall & !pipe_hold and saturates at all-ones.
//  - Same-cycle read/write of the same reg by the retiring last stage is not forwarded. The regfile is write-first.
//  - rdy_stg >= NSTAGE is illegal: the entry never becomes ready. The bench asserts it never occurs.
//  - Mid-operation reset drops all in-flight tags. There is no partial state.
// TESTING
//  1. ALU chain: add x5 (rdy 0), then ID reads x5
//     -> fwd_hit[0]=1, fwd_data=stg_data[0], stall=0.
//  2. Load-use: lw x6 (rdy 1) in stage 0, ID reads x6
//     -> stall=1 for 1 cycle, bubble in stage 0.
//     -> next cycle fwd from stage 1; stall_cnt=1.
//  3. Shadowing: stage 0 writes x7 (rdy 1, unready), stage 1 writes x7 (ready)
//     -> stall=1; the stage-1 value is not forwarded.
//  4. x0 and no-write: entry wnum=0 or id_wr=0, ID reads x0 -> fwd_hit=0, stall=0.
//  5. flush during load-use stall -> stall=0, entries 0 and 1 bubbles next cycle.
//  6. pipe_hold 3 cycles during stall -> tags and stall_cnt unchanged.
//     rst mid-stream -> all fwd_hit=0, stall_cnt=0.

Source files
------------

// File: rtl/fwd_scoreboard_if.sv
// ID-stage operand bypass bundle between the pipeline and the forwarding scoreboard.
interface fwd_scoreboard_if #(
  parameter int XLEN   = 32,
  parameter int NSTAGE = 3,
  parameter int NRD    = 2,
  parameter int RDYW   = 2,
  parameter int CNTW   = 16
);
  logic                   id_valid;
  logic [NRD*5-1:0]       id_rnum;
  logic                   id_wr;
  logic [4:0]             id_wnum;
  logic [RDYW-1:0]        id_rdy_stg;
  logic                   pipe_hold;
  logic                   flush;
  logic [NSTAGE*XLEN-1:0] stg_data;
  logic [NRD-1:0]         fwd_hit;
  logic [NRD*XLEN-1:0]    fwd_data;
  logic                   stall;
  logic [CNTW-1:0]        stall_cnt;

  modport master (
    output id_valid, id_rnum, id_wr, id_wnum, id_rdy_stg, pipe_hold, flush, stg_data,
    input  fwd_hit, fwd_data, stall, stall_cnt
  );

  modport slave (
    input  id_valid, id_rnum, id_wr, id_wnum, id_rdy_stg, pipe_hold, flush, stg_data,
    output fwd_hit, fwd_data, stall, stall_cnt
  );
endinterface

// File: rtl/fwd_scoreboard.sv
// Forwarding/hazard unit: tag pipeline of in-flight register writes, per-port bypass
// select from the youngest matching entry, and load-use stall generation.
module fwd_scoreboard #(
  parameter int XLEN   = 32,
  parameter int NSTAGE = 3,
  parameter int NRD    = 2,
  parameter int RDYW   = 2,
  parameter int CNTW   = 16
) (
  input  logic              clk,
  input  logic              rst,
  fwd_scoreboard_if.slave   bus
);

  typedef struct packed {
    logic            v;
    logic [4:0]      wnum;
    logic [RDYW-1:0] rdy_stg;
  } tag_t;

  localparam tag_t BUBBLE = '0;

  tag_t            ent_q [NSTAGE];
  tag_t            ent_d [NSTAGE];
  logic [CNTW-1:0] cnt_q, cnt_d;

  logic [NRD-1:0]      hit;
  logic [NRD-1:0]      stall_req;
  logic [NRD*XLEN-1:0] data;
  logic                stall;
  tag_t                id_tag;

  // Scan oldest to youngest so the youngest match is the last one written and wins.
  always_comb begin
    hit       = '0;
    data      = '0;
    stall_req = '0;
    for (int p = 0; p < NRD; p++) begin
      for (int k = NSTAGE - 1; k >= 0; k--) begin
        if (ent_q[k].v && ent_q[k].wnum == bus.id_rnum[5*p +: 5] &&
            bus.id_rnum[5*p +: 5] != 5'd0) begin
          if (k >= int'(ent_q[k].rdy_stg)) begin
            hit[p]               = 1'b1;
            data[p*XLEN +: XLEN] = bus.stg_data[k*XLEN +: XLEN];
            stall_req[p]         = 1'b0;
          end else begin
            hit[p]               = 1'b0;
            data[p*XLEN +: XLEN] = '0;
            stall_req[p]         = 1'b1;
          end
        end
      end
    end
    stall = bus.id_valid & ~bus.flush & (|stall_req);
  end

  always_comb begin
    id_tag.v       = bus.id_wr & (|bus.id_wnum);
    id_tag.wnum    = bus.id_wnum;
    id_tag.rdy_stg = bus.id_rdy_stg;
    ent_d          = ent_q;
    cnt_d          = cnt_q;
    if (!bus.pipe_hold) begin
      for (int k = NSTAGE - 1; k >= 1; k--) begin
        ent_d[k] = ent_q[k-1];
      end
      ent_d[0] = (bus.flush || stall || !bus.id_valid) ? BUBBLE : id_tag;
      // The op sitting in stage 0 is the one killed by the branch.
      if (bus.flush) begin
        ent_d[1] = BUBBLE;
      end
      if (stall && !(&cnt_q)) begin
        cnt_d = cnt_q + CNTW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NSTAGE; k++) begin
        ent_q[k] <= BUBBLE;
      end
      cnt_q <= '0;
    end else begin
      ent_q <= ent_d;
      cnt_q <= cnt_d;
    end
  end

  assign bus.fwd_hit   = hit;
  assign bus.fwd_data  = data;
  assign bus.stall     = stall;
  assign bus.stall_cnt = cnt_q;

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Scoreboard bench for fwd_scoreboard: per-cycle expectations are queued as stimulus is
// driven and popped against the DUT outputs on the falling edge.
module tb_fwd_scoreboard;

  localparam int XLEN   = 32;
  localparam int NSTAGE = 3;
  localparam int NRD    = 2;
  localparam int RDYW   = 2;
  localparam int CNTW   = 3;
  localparam logic [XLEN-1:0] S0 = 32'h0000_1000;
  localparam logic [XLEN-1:0] S1 = 32'h0000_2000;
  localparam logic [XLEN-1:0] S2 = 32'h0000_3000;
  localparam int CNT_MAX = (1 << CNTW) - 1;

  typedef struct {
    string           tag;
    logic [1:0]      hit;
    logic [XLEN-1:0] d0;
    logic [XLEN-1:0] d1;
    logic            stall;
    logic [CNTW-1:0] cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   exp_cnt = 0;

  fwd_scoreboard_if #(.XLEN(XLEN), .NSTAGE(NSTAGE), .NRD(NRD), .RDYW(RDYW), .CNTW(CNTW)) bus ();

  fwd_scoreboard #(.XLEN(XLEN), .NSTAGE(NSTAGE), .NRD(NRD), .RDYW(RDYW), .CNTW(CNTW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk_val({e.tag, ".hit"},   64'(bus.fwd_hit), 64'(e.hit));
      chk_val({e.tag, ".d0"},    64'(bus.fwd_data[0 +: XLEN]), 64'(e.d0));
      chk_val({e.tag, ".d1"},    64'(bus.fwd_data[XLEN +: XLEN]), 64'(e.d1));
      chk_val({e.tag, ".stall"}, 64'(bus.stall), 64'(e.stall));
      chk_val({e.tag, ".cnt"},   64'(bus.stall_cnt), 64'(e.cnt));
    end
  end

  always @(posedge clk) begin
    if (!rst && bus.id_valid && bus.id_wr)
      assert (int'(bus.id_rdy_stg) < NSTAGE) else $error("illegal id_rdy_stg %0d", bus.id_rdy_stg);
  end

  // One ID cycle: drive inputs, queue the expected outputs, advance the model counter.
  task automatic step(input string tag, input bit v, input bit wr, input logic [4:0] wn,
                      input logic [1:0] rdy, input logic [4:0] r0, input logic [4:0] r1,
                      input bit hold, input bit fl, input logic [1:0] hit,
                      input logic [XLEN-1:0] d0, input logic [XLEN-1:0] d1, input bit st);
    exp_t e;
    bus.id_valid   = v;
    bus.id_wr      = wr;
    bus.id_wnum    = wn;
    bus.id_rdy_stg = rdy;
    bus.id_rnum    = {r1, r0};
    bus.pipe_hold  = hold;
    bus.flush      = fl;
    e.tag = tag; e.hit = hit; e.d0 = d0; e.d1 = d1; e.stall = st; e.cnt = CNTW'(exp_cnt);
    exp_q.push_back(e);
    if (st && !hold && exp_cnt < CNT_MAX) exp_cnt++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bus.id_valid = 0; bus.id_wr = 0; bus.id_wnum = 0; bus.id_rdy_stg = 0;
    bus.id_rnum = 0; bus.pipe_hold = 0; bus.flush = 0;
    bus.stg_data = {S2, S1, S0};
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    step("reset",    0,0,0,0,  0,0, 0,0, 2'b00, 0, 0, 0);
    // ALU chain: result ready from stage 0 onward
    step("alu_wr",   1,1,5,0,  0,0, 0,0, 2'b00, 0, 0, 0);
    step("alu_s0",   1,0,0,0,  5,0, 0,0, 2'b01, S0, 0, 0);
    step("alu_s1",   1,0,0,0,  0,5, 0,0, 2'b10, 0, S1, 0);
    step("alu_s2",   1,0,0,0,  0,5, 0,0, 2'b10, 0, S2, 0);
    step("alu_ret",  1,0,0,0,  5,5, 0,0, 2'b00, 0, 0, 0);
    // Load-use: one bubble, then bypass from stage 1
    step("lu_wr",    1,1,6,1,  0,0, 0,0, 2'b00, 0, 0, 0);
    step("lu_stall", 1,0,0,0,  6,0, 0,0, 2'b00, 0, 0, 1);
    step("lu_fwd",   1,0,0,0,  6,0, 0,0, 2'b01, S1, 0, 0);
    step("lu_idle",  0,0,0,0,  0,0, 0,0, 2'b00, 0, 0, 0);
    // Shadowing: younger unready x7 hides older ready x7
    step("sh_wr0",   1,1,7,0,  0,0, 0,0, 2'b00, 0, 0, 0);
    step("sh_wr1",   1,1,7,1,  0,0, 0,0, 2'b00, 0, 0, 0);
    step("sh_stall", 1,0,0,0,  7,7, 0,0, 2'b00, 0, 0, 1);
    step("sh_fwd",   1,0,0,0,  7,7, 0,0, 2'b11, S1, S1, 0);
    step("sh_inval", 0,0,0,0,  7,7, 0,0, 2'b11, S2, S2, 0);
    // x0 destination and non-writing instruction never create matches
    step("x0_wr",    1,1,0,0,  0,0, 0,0, 2'b00, 0, 0, 0);
    step("nowr",     1,0,9,0,  0,0, 0,0, 2'b00, 0, 0, 0);
    step("x0_rd",    1,0,0,0,  0,9, 0,0, 2'b00, 0, 0, 0);
    // Flush during load-use: no stall, stage 0 and 1 become bubbles
    step("fl_wr",    1,1,6,1,  0,0, 0,0, 2'b00, 0, 0, 0);
    step("fl_flush", 1,1,8,0,  6,0, 0,1, 2'b00, 0, 0, 0);
    step("fl_after", 1,0,0,0,  6,8, 0,0, 2'b00, 0, 0, 0);
    // pipe_hold during a stall freezes tags and counter
    step("ph_wr",    1,1,6,1,  0,0, 0,0, 2'b00, 0, 0, 0);
    for (int i = 0; i < 3; i++)
      step("ph_hold", 1,0,0,0, 6,0, 1,0, 2'b00, 0, 0, 1);
    step("ph_rel",   1,0,0,0,  6,0, 0,0, 2'b00, 0, 0, 1);
    step("ph_fwd",   1,0,0,0,  6,0, 0,0, 2'b01, S1, 0, 0);
    step("rs_wr",    1,1,10,0, 6,0, 0,0, 2'b01, S2, 0, 0);
    // Mid-stream reset drops x10 and clears the counter
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    exp_cnt = 0;
    step("rs_after", 1,0,0,0,  10,10, 0,0, 2'b00, 0, 0, 0);
    // Counter saturation: two stalls per rdy_stg=2 load, eight stalls in total
    for (int i = 0; i < 4; i++) begin
      step("sat_ld",  1,1,6,2, 0,0, 0,0, 2'b00, 0, 0, 0);
      step("sat_st0", 1,0,0,0, 6,0, 0,0, 2'b00, 0, 0, 1);
      step("sat_st1", 1,0,0,0, 6,0, 0,0, 2'b00, 0, 0, 1);
      step("sat_hit", 1,0,0,0, 6,0, 0,0, 2'b01, S2, 0, 0);
    end
    step("sat_end",  0,0,0,0,  0,0, 0,0, 2'b00, 0, 0, 0);

    @(negedge clk);
    chk_val("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
